// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: round-robin owner of the shared DDR read port; drives the read-mux select
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_weights/req_bias/req_data      level requests from the three loaders
//   len_weights/len_bias/len_data      transfer length in 64-bit words, sampled at grant
//   ddr_conf                           muxed conf pulse from the granted loader
//   ddr_fifo_req, ddr_fifo_empty       muxed pop request and FIFO empty; a beat is req & ~empty
//   switch                             mux select: 0 idle, 1 weights, 2 bias, 3 data
//   grant, done                        one-hot grant and one-cycle done pulse {data,bias,weights}
//   busy                               high outside IDLE
//   err_beat                           sticky flag for a pop beat seen outside XFER
module ddr_rd_arbiter #(
    parameter int SINGLE_LEN = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_weights,
    input  logic                  req_bias,
    input  logic                  req_data,
    input  logic [SINGLE_LEN-1:0] len_weights,
    input  logic [SINGLE_LEN-1:0] len_bias,
    input  logic [SINGLE_LEN-1:0] len_data,
    input  logic                  ddr_conf,
    input  logic                  ddr_fifo_req,
    input  logic                  ddr_fifo_empty,
    output logic [1:0]            switch,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic                  busy,
    output logic                  err_beat
);
    typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;
    state_t                state_q, state_d;
    logic [1:0]            switch_q, switch_d, rr_q, rr_d, ch_q, ch_d, c1, c2, sel;
    logic [2:0]            grant_q, grant_d, done_q, done_d, req;
    logic                  err_q, err_d, beat;
    logic [SINGLE_LEN-1:0] cnt_q, cnt_d, len_q, len_d, sel_len;
    function automatic logic [1:0] nxt(input logic [1:0] i);
        return i == 2'd2 ? 2'd0 : i + 2'd1;
    endfunction
    assign req  = {req_data, req_bias, req_weights};
    assign beat = ddr_fifo_req & ~ddr_fifo_empty;
    // rr_q holds the channel with top priority; search forward from it
    assign c1      = nxt(rr_q);
    assign c2      = nxt(c1);
    assign sel     = req[rr_q] ? rr_q : req[c1] ? c1 : c2;
    assign sel_len = sel == 2'd0 ? len_weights : sel == 2'd1 ? len_bias : len_data;
    always_comb begin
        state_d  = state_q;
        switch_d = switch_q;
        grant_d  = grant_q;
        done_d   = '0;
        rr_d     = rr_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        err_d    = err_q | (beat & (state_q != XFER));
        case (state_q)
            IDLE: if (|req) begin
                state_d  = GRANT;
                ch_d     = sel;
                len_d    = sel_len;
                cnt_d    = '0;
                switch_d = sel + 2'd1;
                grant_d  = 3'b001 << sel;
            end
            GRANT: if (ddr_conf) state_d = len_q == '0 ? DONE : XFER;
            XFER: if (beat) begin
                cnt_d = cnt_q + 1'b1;
                // completion on the last beat keeps the counter from ever wrapping
                if (cnt_q == len_q - 1'b1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                rr_d    = nxt(ch_q);
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) begin
            switch_d = 2'd0;
            grant_d  = '0;
            done_d   = 3'b001 << ch_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            switch_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            rr_q     <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            switch_q <= switch_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            rr_q     <= rr_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            err_q    <= err_d;
        end
    end
    assign switch   = switch_q;
    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = state_q != IDLE;
    assign err_beat = err_q;
endmodule
